// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage access controller.
// Holds the FSM state encoding, data width and the default abort timeout.
package mem_stage_pkg;

  localparam int DATA_W      = 16;
  localparam int TIMEOUT_DEF = 15;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] RESP   = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_REQ    = REQ,
    ST_WAIT   = WAIT,
    ST_RESP   = RESP,
    ST_HALTED = HALTED
  } state_t;

  // A 16-bit access is misaligned when it targets an odd byte address.
  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_wait_cnt.sv
// Clearable up-counter that flags the cycle in which it reaches TIMEOUT.
// tc is combinational from the registered count; no backpressure.
module wait_cnt #(
  parameter int CW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Terminal count fires in the cycle whose increment lands on TIMEOUT.
  assign tc = inc & (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: one-cycle dm_en command, waits for dm_done, pulses wb_valid; stall holds upstream.
// Min load latency request->wb_valid is 3 cycles; dm_busy delays the command. MEM_ALIGN_CHK_EN rejects odd addresses.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_memen,
  input  logic              ex_memwr,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_halt,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              err,
  output logic              halted,
  output logic              dm_en,
  output logic              dm_wr,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_dump,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_done,
  input  logic              dm_busy
);

  state_t state;
  logic   cmd_wr;
  logic   cnt_tc;
  logic   req_halt;
  logic   req_mem;
  logic   misaligned;

  assign req_halt = ex_valid & ex_halt;
  assign req_mem  = ex_valid & ex_memen;

`ifdef MEM_ALIGN_CHK_EN
  assign misaligned = is_misaligned(ex_addr);
`else
  assign misaligned = 1'b0;
`endif

  wait_cnt #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == ST_REQ),
    .inc (state == ST_WAIT),
    .tc  (cnt_tc)
  );

  assign stall = ((state == ST_IDLE) & ex_valid & (ex_memen | ex_halt))
               | (state == ST_REQ)
               | (state == ST_WAIT)
               | (state == ST_HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cmd_wr   <= 1'b0;
      dm_en    <= 1'b0;
      dm_wr    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_dump  <= 1'b0;
      wb_valid <= 1'b0;
      wb_rdata <= '0;
      err      <= 1'b0;
      halted   <= 1'b0;
    end else begin
      dm_en    <= 1'b0;
      dm_wr    <= 1'b0;
      dm_dump  <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_halt) begin
            dm_dump <= 1'b1;
            halted  <= 1'b1;
            state   <= ST_HALTED;
          end else if (req_mem) begin
            if (misaligned) begin
              // Rejected without touching memory, so dm_busy is irrelevant.
              err      <= 1'b1;
              wb_rdata <= '0;
              wb_valid <= 1'b1;
              state    <= ST_RESP;
            end else if (!dm_busy) begin
              dm_addr  <= ex_addr;
              dm_wdata <= ex_wdata;
              cmd_wr   <= ex_memwr;
              dm_en    <= 1'b1;
              dm_wr    <= ex_memwr;
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dm_done) begin
            if (!cmd_wr) begin
              wb_rdata <= dm_rdata;
            end
            wb_valid <= 1'b1;
            state    <= ST_RESP;
          end else if (cnt_tc) begin
            err      <= 1'b1;
            wb_rdata <= '0;
            wb_valid <= 1'b1;
            state    <= ST_RESP;
          end
        end
        // EX still shows the finished instruction here, so it is not re-examined.
        ST_RESP: begin
          state <= ST_IDLE;
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
